gpu_cmd_dispatcher: RTL
=======================

Name: gpu_cmd_dispatcher

Overview:
Parametrised command dispatcher between the GPU command FIFO and the raster engines (line, rectangle fill, circle). It pops one command per dispatch and latches its fields into registered outputs. It fires a one-cycle start pulse to the selected engine and tracks completion per engine. A programmable watchdog aborts engines that never finish, and illegal opcodes are counted and dropped.

Parameters:
WIDTH_BITS, 10, x coordinate and radius width
HEIGHT_BITS, 9, y coordinate width
CHANNEL_BITS, 8, per-colour-channel width
TIMEOUT_BITS, 16, watchdog counter width
TIMEOUT_CYCLES, 50000, WAIT cycles before abort; 0 disables the watchdog
ERR_BITS, 4, illegal-opcode counter width

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous active-low reset
fifo_empty_i  in  1  command FIFO empty; head fields valid when low (show-ahead FIFO)
opcode_i  in  4  head opcode
x1_i, x2_i  in  WIDTH_BITS  head x coordinates
y1_i, y2_i  in  HEIGHT_BITS  head y coordinates
rad_i  in  WIDTH_BITS  head radius
r_i, g_i, b_i  in  CHANNEL_BITS  head colour
done_line_i, done_fill_i, done_circle_i  in  1  engine completion, single-cycle pulse
pop_o  out  1  one-cycle FIFO pop
x1_o, x2_o  out  WIDTH_BITS  latched x coordinates
y1_o, y2_o  out  HEIGHT_BITS  latched y coordinates
rad_o  out  WIDTH_BITS  latched radius
r_o, g_o, b_o  out  CHANNEL_BITS  latched colour
run_line_o, run_fill_o, run_circle_o  out  1  one-cycle engine start
abort_o  out  1  one-cycle abort to all engines on timeout
busy_o  out  1  high whenever state is not IDLE
illegal_o  out  1  one-cycle pulse per dropped illegal opcode
err_count_o  out  ERR_BITS  saturating illegal-opcode count

Behaviour:
- Reset is sampled on the clk rising edge with n_rst low. All outputs go to 0, state goes to IDLE, and the timeout and error counters clear. Reset overrides everything, including mid-WAIT; no abort is issued on reset.
- Opcode map: 4'h0 NOP; 4'h4 LINE; 4'h5 FILL; 4'h6 CIRCLE; all other values are illegal.
- States: IDLE, DISPATCH, WAIT.
- IDLE with fifo_empty_i=0: pop_o=1 combinationally in that cycle, and the same edge captures the head fields, opcode included.
  - LINE, FILL or CIRCLE: next state DISPATCH.
  - NOP: stay in IDLE.
  - Illegal: stay in IDLE, illegal_o pulses next cycle, err_count_o increments and saturates at all-ones.
  - Data outputs are not updated for NOP or illegal commands.
- IDLE with fifo_empty_i=1: no pop.
- DISPATCH lasts one cycle. Exactly one run_*_o is high, chosen by the latched opcode. The timeout counter clears. Next state is WAIT.
  - Latency: pop in cycle N, run in cycle N+1.
- WAIT:
  - Only the done input of the active engine is honoured; done from other engines is ignored.
  - On active done: next state IDLE. The next pop can occur in the cycle after done, giving a 3-cycle minimum command period.
  - Otherwise the counter increments each cycle. When the counter equals TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES≠0, abort_o pulses for one cycle and next state is IDLE.
  - If done and the timeout condition occur in the same cycle, done wins and there is no abort.
- pop_o is never asserted outside IDLE, and no FIFO reads occur while busy.
- Data outputs hold their last dispatched values until the next LINE, FILL or CIRCLE pop.
- done inputs arriving in IDLE or DISPATCH are ignored.
- The registered pulses run_*_o, abort_o and illegal_o are each exactly one cycle wide.

Test Plan:
- Reset: drive n_rst=0 for 2 cycles mid-WAIT → all outputs 0, busy_o=0, err_count_o=0, no abort_o.
- LINE: opcode 4'h4, x1=10, y1=20, x2=300, y2=200, rgb=FF/80/00 → pop_o in cycle N; run_line_o in cycle N+1 with the latched fields; done_line_i at N+5 → busy_o low at N+6; next pop at N+6 if the FIFO is not empty.
- Back-to-back FILL then CIRCLE (rad=50): stray done_line_i during the FILL WAIT is ignored. done_fill_i → next pop. run_circle_o asserts with rad_o=50, and the x/y/colour outputs hold the FILL values until that pop.
- Illegal opcodes 4'hF ×17 with ERR_BITS=4 → 17 pops, 17 illegal_o pulses, err_count_o saturates at 15, no run pulses, data outputs unchanged.
- Timeout: TIMEOUT_CYCLES=8, CIRCLE with no done → abort_o pulses 8 cycles after entering WAIT, then IDLE. Repeat with done_circle_i on that same cycle → no abort.
- NOP stream with TIMEOUT_CYCLES=0: NOP pops take one cycle each with busy_o staying 0. A LINE with no done stays in WAIT for 1000 cycles without abort.

Source files
------------

// File: rtl/gpu_cmd_dispatcher.sv
// Command dispatcher between the GPU command FIFO and the raster engines.
// Pops one command at a time from a show-ahead FIFO and latches its fields.
// It pulses a start to the selected engine, then waits for that engine's
// done, with a watchdog that aborts engines that never finish.
// Illegal opcodes are popped, counted and dropped.
//
// Ports:
//   clk, n_rst              clock, synchronous active-low reset
//   fifo_empty_i            FIFO empty; head fields valid when low
//   opcode_i .. b_i         head command fields
//   done_*_i                single-cycle engine completion pulses
//   pop_o                   combinational FIFO pop (IDLE only)
//   x1_o .. b_o             fields of the last dispatched draw command
//   run_*_o                 one-cycle engine start pulses
//   abort_o                 one-cycle abort to all engines on timeout
//   busy_o                  high whenever not IDLE
//   illegal_o, err_count_o  dropped-opcode pulse and saturating count
module gpu_cmd_dispatcher #(
    parameter int WIDTH_BITS     = 10,
    parameter int HEIGHT_BITS    = 9,
    parameter int CHANNEL_BITS   = 8,
    parameter int TIMEOUT_BITS   = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int ERR_BITS       = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    fifo_empty_i,
    input  logic [3:0]              opcode_i,
    input  logic [WIDTH_BITS-1:0]   x1_i,
    input  logic [WIDTH_BITS-1:0]   x2_i,
    input  logic [HEIGHT_BITS-1:0]  y1_i,
    input  logic [HEIGHT_BITS-1:0]  y2_i,
    input  logic [WIDTH_BITS-1:0]   rad_i,
    input  logic [CHANNEL_BITS-1:0] r_i,
    input  logic [CHANNEL_BITS-1:0] g_i,
    input  logic [CHANNEL_BITS-1:0] b_i,
    input  logic                    done_line_i,
    input  logic                    done_fill_i,
    input  logic                    done_circle_i,
    output logic                    pop_o,
    output logic [WIDTH_BITS-1:0]   x1_o,
    output logic [WIDTH_BITS-1:0]   x2_o,
    output logic [HEIGHT_BITS-1:0]  y1_o,
    output logic [HEIGHT_BITS-1:0]  y2_o,
    output logic [WIDTH_BITS-1:0]   rad_o,
    output logic [CHANNEL_BITS-1:0] r_o,
    output logic [CHANNEL_BITS-1:0] g_o,
    output logic [CHANNEL_BITS-1:0] b_o,
    output logic                    run_line_o,
    output logic                    run_fill_o,
    output logic                    run_circle_o,
    output logic                    abort_o,
    output logic                    busy_o,
    output logic                    illegal_o,
    output logic [ERR_BITS-1:0]     err_count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_WAIT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LINE = 4'h4;
    localparam logic [3:0] OP_FILL = 4'h5;
    localparam logic [3:0] OP_CIRC = 4'h6;

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_BITS-1:0] TO_LAST =
        TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              op_q, op_d;
    logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH_BITS-1:0]   x1_q, x1_d, x2_q, x2_d, rad_q, rad_d;
    logic [HEIGHT_BITS-1:0]  y1_q, y1_d, y2_q, y2_d;
    logic [CHANNEL_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic                    rl_q, rl_d, rf_q, rf_d, rc_q, rc_d;
    logic                    abort_q, abort_d, ill_q, ill_d;
    logic [ERR_BITS-1:0]     err_q, err_d;
    logic                    pop;
    logic                    legal;
    logic                    act_done;

    assign legal = (opcode_i == OP_LINE) || (opcode_i == OP_FILL) ||
                   (opcode_i == OP_CIRC);

    // Only the engine that was started may end the WAIT.
    assign act_done = ((op_q == OP_LINE) && done_line_i) ||
                      ((op_q == OP_FILL) && done_fill_i) ||
                      ((op_q == OP_CIRC) && done_circle_i);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        rad_d   = rad_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        err_d   = err_q;
        rl_d    = 1'b0;
        rf_d    = 1'b0;
        rc_d    = 1'b0;
        abort_d = 1'b0;
        ill_d   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty_i) begin
                    pop  = 1'b1;
                    op_d = opcode_i;
                    if (legal) begin
                        x1_d    = x1_i;
                        x2_d    = x2_i;
                        y1_d    = y1_i;
                        y2_d    = y2_i;
                        rad_d   = rad_i;
                        r_d     = r_i;
                        g_d     = g_i;
                        b_d     = b_i;
                        rl_d    = (opcode_i == OP_LINE);
                        rf_d    = (opcode_i == OP_FILL);
                        rc_d    = (opcode_i == OP_CIRC);
                        state_d = S_DISPATCH;
                    end else if (opcode_i != OP_NOP) begin
                        ill_d = 1'b1;
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                    end
                end
            end
            S_DISPATCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done takes priority over a coincident timeout.
                if (act_done) begin
                    state_d = S_IDLE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            rad_q   <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            rl_q    <= 1'b0;
            rf_q    <= 1'b0;
            rc_q    <= 1'b0;
            abort_q <= 1'b0;
            ill_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            rad_q   <= rad_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            rl_q    <= rl_d;
            rf_q    <= rf_d;
            rc_q    <= rc_d;
            abort_q <= abort_d;
            ill_q   <= ill_d;
            err_q   <= err_d;
        end
    end

    // Gated with reset so every output reads 0 while reset is held.
    assign pop_o        = pop && n_rst;
    assign x1_o         = x1_q;
    assign x2_o         = x2_q;
    assign y1_o         = y1_q;
    assign y2_o         = y2_q;
    assign rad_o        = rad_q;
    assign r_o          = r_q;
    assign g_o          = g_q;
    assign b_o          = b_q;
    assign run_line_o   = rl_q;
    assign run_fill_o   = rf_q;
    assign run_circle_o = rc_q;
    assign abort_o      = abort_q;
    assign busy_o       = (state_q != S_IDLE);
    assign illegal_o    = ill_q;
    assign err_count_o  = err_q;

endmodule
